// File: rtl/mdu_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode encodings,
// default latencies and opcode classification helpers. The decoder and the
// hazard unit import this package as well.
package mdu_e_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the opcodes that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_muldiv = 1'b1;
            default:                                is_muldiv = 1'b0;
        endcase
    endfunction

    // True for the two divide opcodes (divide-by-zero handling applies).
    function automatic logic is_div(input logic [3:0] op);
        case (op)
            MDU_DIV, MDU_DIVU: is_div = 1'b1;
            default:           is_div = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_e_if.sv
// Pipeline-side connection of the multiply/divide unit. The E stage (master)
// drives the operation and operands; the MDU (slave) returns status and HI/LO.
interface mdu_e_if;
    logic        IntReq;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    modport master (
        output IntReq, MDUOp, A, B,
        input  start, busy, HI, LO, MDU_out
    );

    modport slave (
        input  IntReq, MDUOp, A, B,
        output start, busy, HI, LO, MDU_out
    );
endinterface

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit. Owns HI/LO. A multi-cycle operation computes
// its full result at the start edge, parks it in tmp_hi/tmp_lo, and commits it
// to HI/LO when the latency counter expires. An interrupt flush only blocks
// operations issued in its own cycle; an operation in flight is already
// committed and always finishes.
module mdu_e
    import mdu_e_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   reset,
    mdu_e_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      tmp_hi_r;
    logic [31:0]      tmp_lo_r;
    logic             tmp_wr_r;

    logic             start_s;
    logic [63:0]      prod_signed_s;
    logic [63:0]      prod_unsigned_s;
    logic [31:0]      a_mag_s;
    logic [31:0]      b_mag_s;
    logic [31:0]      sdiv_den_s;
    logic [31:0]      udiv_den_s;
    logic [31:0]      sq_mag_s;
    logic [31:0]      sr_mag_s;
    logic [31:0]      sdiv_q_s;
    logic [31:0]      sdiv_r_s;
    logic [31:0]      udiv_q_s;
    logic [31:0]      udiv_r_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_wr_s;
    logic [31:0]      mdu_out_s;

    // Start request seen by the hazard unit: a mul/div op not being flushed.
    always_comb begin
        start_s = is_muldiv(bus.MDUOp) & ~bus.IntReq;
    end

    // Products: the low 64 bits of a sign-extended product equal the signed
    // 64-bit product, so both flavours use a plain 64-bit multiply.
    always_comb begin
        prod_signed_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_unsigned_s = {32'd0, bus.A} * {32'd0, bus.B};
    end

    // Divides: the signed divide runs on magnitudes so that 0x80000000 / -1
    // wraps cleanly to 0x80000000 with remainder 0. Zero denominators are
    // replaced by 1; those results are never committed anyway.
    always_comb begin
        a_mag_s    = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
        b_mag_s    = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
        sdiv_den_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        udiv_den_s = (bus.B == 32'd0) ? 32'd1 : bus.B;
        sq_mag_s   = a_mag_s / sdiv_den_s;
        sr_mag_s   = a_mag_s % sdiv_den_s;
        sdiv_q_s   = (bus.A[31] ^ bus.B[31]) ? (~sq_mag_s + 32'd1) : sq_mag_s;
        sdiv_r_s   = bus.A[31] ? (~sr_mag_s + 32'd1) : sr_mag_s;
        udiv_q_s   = bus.A / udiv_den_s;
        udiv_r_s   = bus.A % udiv_den_s;
    end

    // Select the result to park for the current opcode and decide whether it
    // will be committed (divide by zero leaves HI/LO untouched).
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_wr_s = 1'b1;
        case (bus.MDUOp)
            MDU_MULT: begin
                res_hi_s = prod_signed_s[63:32];
                res_lo_s = prod_signed_s[31:0];
            end
            MDU_MULTU: begin
                res_hi_s = prod_unsigned_s[63:32];
                res_lo_s = prod_unsigned_s[31:0];
            end
            MDU_DIV: begin
                res_hi_s = sdiv_r_s;
                res_lo_s = sdiv_q_s;
            end
            MDU_DIVU: begin
                res_hi_s = udiv_r_s;
                res_lo_s = udiv_q_s;
            end
            default: begin
                res_wr_s = 1'b0;
            end
        endcase
        if (is_div(bus.MDUOp) && (bus.B == 32'd0)) begin
            res_wr_s = 1'b0;
        end else begin
            res_wr_s = res_wr_s;
        end
    end

    // Latency counter, pending result and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            tmp_hi_r <= 32'd0;
            tmp_lo_r <= 32'd0;
            tmp_wr_r <= 1'b0;
        end else if (busy_r) begin
            if (cnt_r == CNT_W'(1)) begin
                cnt_r  <= {CNT_W{1'b0}};
                busy_r <= 1'b0;
                if (tmp_wr_r) begin
                    hi_r <= tmp_hi_r;
                    lo_r <= tmp_lo_r;
                end
            end else begin
                cnt_r  <= cnt_r - CNT_W'(1);
                busy_r <= 1'b1;
            end
        end else if (start_s) begin
            tmp_hi_r <= res_hi_s;
            tmp_lo_r <= res_lo_s;
            tmp_wr_r <= res_wr_s;
            cnt_r    <= is_div(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_r   <= 1'b1;
        end else if (!bus.IntReq) begin
            case (bus.MDUOp)
                MDU_MTHI: hi_r <= bus.A;
                MDU_MTLO: lo_r <= bus.A;
                default:  hi_r <= hi_r;
            endcase
        end else begin
            hi_r <= hi_r;
        end
    end

    // Move-from read port straight off the current HI/LO.
    always_comb begin
        case (bus.MDUOp)
            MDU_MFHI: mdu_out_s = hi_r;
            MDU_MFLO: mdu_out_s = lo_r;
            default:  mdu_out_s = 32'd0;
        endcase
    end

    assign bus.start   = start_s;
    assign bus.busy    = busy_r;
    assign bus.HI      = hi_r;
    assign bus.LO      = lo_r;
    assign bus.MDU_out = mdu_out_s;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed corner cases followed by random
// operations, checked against an arithmetic reference of HI/LO behaviour.
module tb_mdu_e;
    import mdu_e_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_e_if bus();

    mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result of a mul/div op using 64-bit integer arithmetic.
    function automatic void ref_result(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic wr,
                                       output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        wr = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MDU_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            MDU_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            MDU_DIV: begin
                if (b == 32'd0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            MDU_DIVU: begin
                if (b == 32'd0) wr = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    task automatic drive_idle();
        bus.MDUOp  = 4'd0;
        bus.IntReq = 1'b0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
    endtask

    // Issue one instruction in E for one cycle and follow it to completion.
    // irq_at / poke_at: busy-cycle index at which to raise IntReq or present a
    // second mult (both must leave the in-flight op untouched); -1 disables.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic irq, input int irq_at, input int poke_at);
        logic        exp_start;
        logic        wr;
        logic [31:0] rh, rl, exp_out;
        int          n;
        exp_start = (op >= 4'd1) && (op <= 4'd4) && !irq;
        exp_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        @(negedge clk);
        bus.MDUOp = op; bus.A = a; bus.B = b; bus.IntReq = irq;
        #1;
        check("start", bus.start, exp_start);
        check("mdu_out", bus.MDU_out, exp_out);
        check("busy_before", bus.busy, 1'b0);
        ref_result(op, a, b, wr, rh, rl);
        n = (op == 4'd1 || op == 4'd2) ? MC : DC;
        @(negedge clk);
        drive_idle();
        if (exp_start) begin
            for (int k = 1; k <= n; k++) begin
                check("busy_run", bus.busy, 1'b1);
                check("hi_hold", bus.HI, m_hi);
                check("lo_hold", bus.LO, m_lo);
                if (k == irq_at) bus.IntReq = 1'b1;
                if (k == poke_at) begin
                    bus.MDUOp = 4'd1; bus.A = $urandom; bus.B = $urandom;
                end
                @(negedge clk);
                drive_idle();
            end
            if (wr) begin
                m_hi = rh;
                m_lo = rl;
            end
        end else if (!irq && op == 4'd5) begin
            m_hi = a;
        end else if (!irq && op == 4'd6) begin
            m_lo = a;
        end
        check("busy_done", bus.busy, 1'b0);
        check("hi", bus.HI, m_hi);
        check("lo", bus.LO, m_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_out", bus.MDU_out, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;

        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, -1, -1);
        check("mult_hi", bus.HI, 32'hFFFFFFFF);
        check("mult_lo", bus.LO, 32'hFFFFFFFA);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1);
        check("multu_hi", bus.HI, 32'hFFFFFFFE);
        check("multu_lo", bus.LO, 32'h00000001);
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, -1, -1);
        check("div_hi", bus.HI, 32'hFFFFFFFF);
        check("div_lo", bus.LO, 32'hFFFFFFFD);
        issue(4'd4, 32'd7, 32'd0, 1'b0, -1, -1);
        check("divu0_hi", bus.HI, 32'hFFFFFFFF);
        check("divu0_lo", bus.LO, 32'hFFFFFFFD);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, -1);
        check("divovf_hi", bus.HI, 32'h00000000);
        check("divovf_lo", bus.LO, 32'h80000000);

        issue(4'd5, 32'h12345678, 32'd0, 1'b1, -1, -1);
        check("mthi_irq", bus.HI, 32'h00000000);
        issue(4'd5, 32'h12345678, 32'd0, 1'b0, -1, -1);
        check("mthi", bus.HI, 32'h12345678);
        issue(4'd7, 32'd0, 32'd0, 1'b0, -1, -1);
        @(negedge clk);
        bus.MDUOp = 4'd7;
        #1;
        check("mfhi_const", bus.MDU_out, 32'h12345678);
        drive_idle();
        issue(4'd6, 32'hCAFEF00D, 32'd0, 1'b0, -1, -1);
        issue(4'd8, 32'd0, 32'd0, 1'b0, -1, -1);

        issue(4'd1, 32'h00012345, 32'hFFFF0003, 1'b0, 2, -1);
        issue(4'd3, 32'd1000, 32'd7, 1'b0, -1, 3);

        // Reset four cycles into a divide: aborts with no late write.
        @(negedge clk);
        bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_hi", bus.HI, 32'd0);
        check("rstmid_lo", bus.LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (8) @(negedge clk);
        check("rstlate_busy", bus.busy, 1'b0);
        check("rstlate_hi", bus.HI, 32'd0);
        check("rstlate_lo", bus.LO, 32'd0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 4);
            ra  = $urandom;
            rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) :
                  (sel == 2) ? -32'($urandom_range(1, 9)) : $urandom;
            if ($urandom_range(0, 2) == 0) ra = 32'($urandom_range(0, 100));
            issue(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) == 0), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
